// File: rtl/alarm_array_pkg.sv
// Shared types and default constants for the alarm_array slice.
// Holds the per-channel state enum, default parameter values and a small
// decode helper used by the channel logic.
package alarm_array_pkg;

  // Default build-time configuration
  localparam int DEF_NCH      = 8;
  localparam int DEF_DEB_CYC  = 4;
  localparam int DEF_BEEP_PER = 8;
  localparam int DEF_HOLD_CYC = 16;

  // Per-channel alarm state
  typedef enum logic [2:0] {
    CH_IDLE   = 3'd0,
    CH_ARMING = 3'd1,
    CH_ALARM  = 3'd2,
    CH_HOLD   = 3'd3,
    CH_MUTED  = 3'd4
  } chan_state_e;

  // A channel is sounding (active) only while in ALARM or HOLD
  function automatic logic is_sounding(input chan_state_e st);
    return (st == CH_ALARM) || (st == CH_HOLD);
  endfunction

endpackage : alarm_array_pkg

// File: rtl/alarm_chan.sv
// One alarm channel: single-flop sensor capture, debounce, beeping alarm,
// post-release hold window and acknowledge-to-mute.
// Build macro ALARM_ARRAY_LATCH_EN: when defined, HOLD never times out and
// is left only by ack, ena=0 or rst (sensor reassertion still returns to ALARM).
module alarm_chan
  import alarm_array_pkg::*;
#(
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int BEEP_PER = DEF_BEEP_PER,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic ena_i,
  input  logic sensor_i,
  input  logic ack_i,
  output logic buzzer_o,
  output logic active_o
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int BEEP_W = $clog2(BEEP_PER + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  logic              s_q;
  chan_state_e       state_q,  state_d;
  logic [DEB_W-1:0]  deb_q,    deb_d;
  logic [BEEP_W-1:0] beep_q,   beep_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic              buzz_q,   buzz_d;
  logic              active_q, active_d;

  // Beep phase advance used by every cycle spent in ALARM or HOLD
  logic              beep_wrap;
  logic [BEEP_W-1:0] beep_next;
  logic              buzz_next;

  assign beep_wrap = (beep_q == BEEP_W'(BEEP_PER - 1));
  assign beep_next = beep_wrap ? '0 : beep_q + BEEP_W'(1);
  assign buzz_next = beep_wrap ? ~buzz_q : buzz_q;

  // State register, counters, registered outputs and the sensor capture flop
  // NOTE: asynchronous reset acts without a clock edge; every flop here gets a defined reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= 1'b0;
      state_q  <= CH_IDLE;
      deb_q    <= '0;
      beep_q   <= '0;
      hold_q   <= '0;
      buzz_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s_q      <= sensor_i;
      state_q  <= state_d;
      deb_q    <= deb_d;
      beep_q   <= beep_d;
      hold_q   <= hold_d;
      buzz_q   <= buzz_d;
      active_q <= active_d;
    end
  end

  // Next-state and counter logic; ena low overrides everything, then ack wins over sensor
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    deb_d   = deb_q;
    beep_d  = beep_q;
    hold_d  = hold_q;
    buzz_d  = buzz_q;

    if (!ena_i) begin
      state_d = CH_IDLE;
      deb_d   = '0;
      beep_d  = '0;
      hold_d  = '0;
      buzz_d  = 1'b0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (s_q) begin
            if (DEB_CYC == 1) begin
              state_d = CH_ALARM;
              beep_d  = '0;
              buzz_d  = 1'b1;
            end else begin
              state_d = CH_ARMING;
              deb_d   = DEB_W'(1);
            end
          end
        end

        CH_ARMING: begin
          if (!s_q) begin
            state_d = CH_IDLE;
            deb_d   = '0;
          end else if (deb_q == DEB_W'(DEB_CYC - 1)) begin
            state_d = CH_ALARM;
            deb_d   = '0;
            beep_d  = '0;
            buzz_d  = 1'b1;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end

        CH_ALARM: begin
          if (ack_i) begin
            state_d = CH_MUTED;
            beep_d  = '0;
            hold_d  = '0;
            buzz_d  = 1'b0;
          end else begin
            beep_d = beep_next;
            buzz_d = buzz_next;
            if (!s_q) begin
              state_d = CH_HOLD;
              hold_d  = HOLD_W'(HOLD_CYC);
            end
          end
        end

        CH_HOLD: begin
          if (ack_i) begin
            state_d = CH_MUTED;
            beep_d  = '0;
            hold_d  = '0;
            buzz_d  = 1'b0;
          end else if (s_q) begin
            // Sensor back: resume alarm, beep phase keeps running
            state_d = CH_ALARM;
            hold_d  = '0;
            beep_d  = beep_next;
            buzz_d  = buzz_next;
          end else begin
            beep_d = beep_next;
            buzz_d = buzz_next;
`ifdef ALARM_ARRAY_LATCH_EN
            // Latched alarm: hold window never expires
`else
            if (hold_q == HOLD_W'(1)) begin
              state_d = CH_IDLE;
              hold_d  = '0;
              beep_d  = '0;
              buzz_d  = 1'b0;
            end else begin
              hold_d = hold_q - HOLD_W'(1);
            end
`endif
          end
        end

        CH_MUTED: begin
          if (!s_q) begin
            state_d = CH_IDLE;
          end
        end

        default: begin
          state_d = CH_IDLE;
          deb_d   = '0;
          beep_d  = '0;
          hold_d  = '0;
          buzz_d  = 1'b0;
        end
      endcase
    end

    active_d = is_sounding(state_d);
  end

  assign buzzer_o = buzz_q;
  assign active_o = active_q;

endmodule : alarm_chan

// File: rtl/alarm_array.sv
// Top level of the alarm array: NCH independent alarm channels plus a
// summary flag. Build macro ALARM_ARRAY_LATCH_EN (see alarm_chan) selects
// latched HOLD behaviour.
module alarm_array
  import alarm_array_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int BEEP_PER = DEF_BEEP_PER,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [NCH-1:0] sensor,
  input  logic [NCH-1:0] ack,
  output logic [NCH-1:0] buzzer,
  output logic [NCH-1:0] active,
  output logic           any_active
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    alarm_chan #(
      .DEB_CYC  (DEB_CYC),
      .BEEP_PER (BEEP_PER),
      .HOLD_CYC (HOLD_CYC)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .ena_i    (ena),
      .sensor_i (sensor[g]),
      .ack_i    (ack[g]),
      .buzzer_o (buzzer[g]),
      .active_o (active[g])
    );
  end

  assign any_active = |active;

endmodule : alarm_array

// File: tb/tb_alarm_array.sv
// Self-checking bench for alarm_array: elapsed-time channel model compared
// every cycle, directed scenarios with literal expectations, then random
// traffic. Honors ALARM_ARRAY_LATCH_EN for the latched-hold build.
module tb_alarm_array;

  localparam int NCH      = 8;
  localparam int DEB_CYC  = 4;
  localparam int BEEP_PER = 8;
  localparam int HOLD_CYC = 16;
`ifdef ALARM_ARRAY_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic [NCH-1:0] sensor;
  logic [NCH-1:0] ack;
  logic [NCH-1:0] buzzer;
  logic [NCH-1:0] active;
  logic           any_active;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  alarm_array #(
    .NCH      (NCH),
    .DEB_CYC  (DEB_CYC),
    .BEEP_PER (BEEP_PER),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .sensor     (sensor),
    .ack        (ack),
    .buzzer     (buzzer),
    .active     (active),
    .any_active (any_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: each channel is described by its captured sample,
  // a run length of high samples, whether it is sounding, cycles elapsed since
  // the alarm started, cycles left in the hold window, and a muted flag.
  int             m_s    [NCH] = '{default: 0};
  int             m_run  [NCH] = '{default: 0};
  int             m_on   [NCH] = '{default: 0};
  int             m_t    [NCH] = '{default: 0};
  int             m_hold [NCH] = '{default: 0};
  int             m_muted[NCH] = '{default: 0};
  logic [NCH-1:0] exp_buz = '0;
  logic [NCH-1:0] exp_act = '0;

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_s[i] = 0; m_run[i] = 0; m_on[i] = 0; m_t[i] = 0; m_hold[i] = 0; m_muted[i] = 0;
      end else begin
        if (!ena) begin
          m_run[i] = 0; m_on[i] = 0; m_t[i] = 0; m_hold[i] = 0; m_muted[i] = 0;
        end else if (m_muted[i] != 0) begin
          if (m_s[i] == 0) m_muted[i] = 0;
        end else if (m_on[i] != 0) begin
          if (ack[i]) begin
            m_on[i] = 0; m_muted[i] = 1; m_t[i] = 0; m_hold[i] = 0;
          end else begin
            m_t[i]++;
            if (m_s[i] != 0)          m_hold[i] = 0;
            else if (m_hold[i] == 0)  m_hold[i] = HOLD_CYC;
            else if (!LATCH) begin
              if (m_hold[i] == 1) begin
                m_on[i] = 0; m_t[i] = 0; m_hold[i] = 0;
              end else begin
                m_hold[i]--;
              end
            end
          end
        end else begin
          if (m_s[i] != 0) begin
            m_run[i]++;
            if (m_run[i] >= DEB_CYC) begin
              m_on[i] = 1; m_t[i] = 0; m_run[i] = 0; m_hold[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_s[i] = sensor[i] ? 1 : 0;
      end
      exp_act[i] = (m_on[i] != 0);
      exp_buz[i] = (m_on[i] != 0) && (((m_t[i] / BEEP_PER) % 2) == 0);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_buzzer", 32'(buzzer), 32'(exp_buz));
      check("cyc_active", 32'(active), 32'(exp_act));
      check("cyc_any",    32'(any_active), 32'(|exp_act));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiesce();
    sensor = '0;
    ack    = '0;
    ena    = 1'b1;
    repeat (2) tick();
    ack = '1;
    tick();
    ack = '0;
    repeat (2) tick();
  endtask

  logic [31:0]    pat;
  logic [NCH-1:0] rnd_s;
  logic [NCH-1:0] rnd_a;
  int             n;

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    sensor = '0;
    ack    = '0;
    pat    = 32'hFF00_FF00;
    #1 cmp_en = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_buzzer", 32'(buzzer), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_any",    32'(any_active), 32'd0);
    rst = 1'b0;

    // Three high samples on channel 0 raise nothing
    tick();
    sensor[0] = 1'b1;
    repeat (3) tick();
    sensor[0] = 1'b0;
    repeat (2) tick();
    check("deb3_buzzer", 32'(buzzer[0]), 32'd0);
    check("deb3_active", 32'(active[0]), 32'd0);
    check("deb3_model",  32'(exp_buz[0]), 32'd0);
    repeat (3) tick();
    check("deb3_late", 32'(active[0]), 32'd0);

    // Four high samples: rise after edge 5
    sensor[0] = 1'b1;
    repeat (4) tick();
    check("deb4_edge4_buz", 32'(buzzer[0]), 32'd0);
    check("deb4_edge4_act", 32'(active[0]), 32'd0);
    tick();
    check("deb4_edge5_buz", 32'(buzzer[0]), 32'd1);
    check("deb4_edge5_act", 32'(active[0]), 32'd1);
    check("deb4_edge5_any", 32'(any_active), 32'd1);
    check("deb4_model",     32'(exp_act[0]), 32'd1);
    quiesce();

    // Channel 1 beep pattern then release into the hold window
    sensor[1] = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      check("beep_pattern", 32'(buzzer[1]), 32'(pat[31-i]));
    end
    sensor[1] = 1'b0;
`ifdef ALARM_ARRAY_LATCH_EN
    repeat (1100) tick();
    check("latch_hold_active", 32'(active[1]), 32'd1);
    ack[1] = 1'b1;
    tick();
    ack[1] = 1'b0;
    check("latch_ack_active", 32'(active[1]), 32'd0);
`else
    n = 0;
    do begin
      tick();
      n++;
    end while (active[1] && n < 100);
    check("hold_release_ticks", 32'(n), 32'd18);
    check("hold_done_buzzer",   32'(buzzer[1]), 32'd0);
    check("hold_done_model",    32'(exp_act[1]), 32'd0);
`endif
    quiesce();

    // Channel 2 released, then reasserted at hold cycle 10
    sensor[2] = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      check("reassert_buzzer", 32'(buzzer[2]), 32'(pat[31-i]));
      check("reassert_active", 32'(active[2]), 32'd1);
      if (i == 3)  sensor[2] = 1'b0;
      if (i == 13) sensor[2] = 1'b1;
    end
    quiesce();

    // Ack on channel 1 mutes it until sensor falls and re-debounces
    sensor[1] = 1'b1;
    repeat (7) tick();
    ack[1] = 1'b1;
    tick();
    ack[1] = 1'b0;
    check("ack_buzzer", 32'(buzzer[1]), 32'd0);
    check("ack_active", 32'(active[1]), 32'd0);
    repeat (10) tick();
    check("muted_stays", 32'(active[1]), 32'd0);
    sensor[1] = 1'b0;
    repeat (2) tick();
    sensor[1] = 1'b1;
    repeat (4) tick();
    check("rearm_early", 32'(active[1]), 32'd0);
    tick();
    check("rearm_rise", 32'(active[1]), 32'd1);
    quiesce();

    // All channels, ena drop, async reset mid-beep
    sensor = '1;
    repeat (5) tick();
    check("all_active", 32'(active), 32'(8'hFF));
    check("all_any",    32'(any_active), 32'd1);
    ena = 1'b0;
    tick();
    check("ena_active", 32'(active), 32'd0);
    check("ena_buzzer", 32'(buzzer), 32'd0);
    check("ena_any",    32'(any_active), 32'd0);
    ena = 1'b1;
    repeat (3) tick();
    check("ena_rearm_early", 32'(active), 32'd0);
    tick();
    check("ena_rearm_rise", 32'(active), 32'(8'hFF));
    repeat (2) tick();
    check("pre_rst_buzzer", 32'(buzzer), 32'(8'hFF));
    #1 rst = 1'b1;
    #1;
    check("async_rst_buzzer", 32'(buzzer), 32'd0);
    check("async_rst_active", 32'(active), 32'd0);
    check("async_rst_any",    32'(any_active), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_early", 32'(active), 32'd0);
    tick();
    check("post_rst_rise", 32'(active), 32'(8'hFF));
    quiesce();

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rnd_s = sensor;
      rnd_a = '0;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 6 + 4 * i) == 0) rnd_s[i] = ~rnd_s[i];
        if ($urandom_range(0, 47) == 0)        rnd_a[i] = 1'b1;
      end
      sensor = rnd_s;
      ack    = rnd_a;
      ena    = ($urandom_range(0, 299) != 0);
      rst    = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0;
    quiesce();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alarm_array
